// File: rtl/enet_bus_controller_if.sv
// Host-side command handshake and chip bus signals of the Ethernet bus controller.
// The controller uses the slave modport; the upstream mux or a bench uses master.
interface enet_bus_controller_if;
    logic        start_comm_in;
    logic [1:0]  comm_type_in;
    logic [7:0]  addr_in;
    logic [15:0] dataw_in;
    logic [2:0]  post_command_delay_in;
    logic        rdy_out;
    logic [15:0] datar_out;
    logic        enet_cs_n_out;
    logic        enet_cmd_out;
    logic        enet_ior_n_out;
    logic        enet_iow_n_out;
    logic [15:0] enet_data_out;
    logic        enet_data_oe_out;
    logic [15:0] enet_data_in;
    logic        cmd_overrun_out;

    modport slave (
        input  start_comm_in, comm_type_in, addr_in, dataw_in, post_command_delay_in,
        input  enet_data_in,
        output rdy_out, datar_out, enet_cs_n_out, enet_cmd_out, enet_ior_n_out,
        output enet_iow_n_out, enet_data_out, enet_data_oe_out, cmd_overrun_out
    );

    modport master (
        output start_comm_in, comm_type_in, addr_in, dataw_in, post_command_delay_in,
        output enet_data_in,
        input  rdy_out, datar_out, enet_cs_n_out, enet_cmd_out, enet_ior_n_out,
        input  enet_iow_n_out, enet_data_out, enet_data_oe_out, cmd_overrun_out
    );
endinterface

// File: rtl/enet_bus_controller.sv
// Single-command index/data host bus sequencer for a DM9000A-style Ethernet MAC.
// Optional macro ENET_OVERRUN_DETECT_EN builds the sticky cmd_overrun_out detector.
module enet_bus_controller #(
    parameter int unsigned PULSE_CYCLES      = 2,
    parameter int unsigned GAP_CYCLES        = 2,
    parameter int unsigned STD_DELAY_CYCLES  = 4,
    parameter int unsigned LONG_DELAY_CYCLES = 200
) (
    input logic                  clk,
    input logic                  rst,
    enet_bus_controller_if.slave bus_io
);
    typedef enum logic [2:0] {
        StIdle, StIdxStrobe, StIdxGap, StDataStrobe, StPostDelay
    } state_e;

    localparam logic [1:0] TypeRead  = 2'd0;
    localparam logic [1:0] TypeWrite = 2'd1;
    localparam logic [1:0] TypeRx    = 2'd3;
    localparam logic [7:0] PulseLd   = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GapLd     = 8'(GAP_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  type_q;
    logic [15:0] dataw_q;
    logic [7:0]  delay_q;
    logic        rdy_q;
    logic [15:0] datar_q;
    logic        cs_n_q, cmd_q, ior_n_q, iow_n_q, oe_q;
    logic [15:0] data_q;

    logic [7:0] delay_dec;
    logic       idx_in, rd_in, rd_q;

    always_comb begin
        delay_dec = 8'd0;
        unique case (bus_io.post_command_delay_in)
            3'd1:    delay_dec = 8'(STD_DELAY_CYCLES);
            3'd2:    delay_dec = 8'(LONG_DELAY_CYCLES);
            default: delay_dec = 8'd0;
        endcase
        idx_in = (bus_io.comm_type_in == TypeRead) || (bus_io.comm_type_in == TypeWrite);
        rd_in  = (bus_io.comm_type_in == TypeRead) || (bus_io.comm_type_in == TypeRx);
        rd_q   = (type_q == TypeRead) || (type_q == TypeRx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            type_q  <= 2'd0;
            dataw_q <= 16'd0;
            delay_q <= 8'd0;
            rdy_q   <= 1'b1;
            datar_q <= 16'd0;
            cs_n_q  <= 1'b1;
            cmd_q   <= 1'b0;
            ior_n_q <= 1'b1;
            iow_n_q <= 1'b1;
            oe_q    <= 1'b0;
            data_q  <= 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.start_comm_in) begin
                        type_q  <= bus_io.comm_type_in;
                        dataw_q <= bus_io.dataw_in;
                        delay_q <= delay_dec;
                        rdy_q   <= 1'b0;
                        cs_n_q  <= 1'b0;
                        cnt_q   <= PulseLd;
                        if (idx_in) begin
                            state_q <= StIdxStrobe;
                            cmd_q   <= 1'b0;
                            data_q  <= {8'h00, bus_io.addr_in};
                            oe_q    <= 1'b1;
                            iow_n_q <= 1'b0;
                        end else begin
                            state_q <= StDataStrobe;
                            cmd_q   <= 1'b1;
                            data_q  <= bus_io.dataw_in;
                            oe_q    <= !rd_in;
                            ior_n_q <= !rd_in;
                            iow_n_q <= rd_in;
                        end
                    end
                end
                StIdxStrobe: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= StIdxGap;
                        iow_n_q <= 1'b1;
                        oe_q    <= 1'b0;
                        cnt_q   <= GapLd;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StIdxGap: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= StDataStrobe;
                        cmd_q   <= 1'b1;
                        data_q  <= dataw_q;
                        oe_q    <= !rd_q;
                        ior_n_q <= !rd_q;
                        iow_n_q <= rd_q;
                        cnt_q   <= PulseLd;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StDataStrobe: begin
                    if (cnt_q == 8'd0) begin
                        ior_n_q <= 1'b1;
                        iow_n_q <= 1'b1;
                        oe_q    <= 1'b0;
                        cs_n_q  <= 1'b1;
                        cmd_q   <= 1'b0;
                        data_q  <= 16'd0;
                        // Bus sampled on the final strobe cycle, just before ior_n rises.
                        if (rd_q) datar_q <= bus_io.enet_data_in;
                        if (delay_q != 8'd0) begin
                            state_q <= StPostDelay;
                            cnt_q   <= delay_q - 8'd1;
                        end else begin
                            state_q <= StIdle;
                            rdy_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StPostDelay: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= StIdle;
                        rdy_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.rdy_out          = rdy_q;
    assign bus_io.datar_out        = datar_q;
    assign bus_io.enet_cs_n_out    = cs_n_q;
    assign bus_io.enet_cmd_out     = cmd_q;
    assign bus_io.enet_ior_n_out   = ior_n_q;
    assign bus_io.enet_iow_n_out   = iow_n_q;
    assign bus_io.enet_data_out    = data_q;
    assign bus_io.enet_data_oe_out = oe_q;

`ifdef ENET_OVERRUN_DETECT_EN
    logic overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (bus_io.start_comm_in && !rdy_q) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus_io.cmd_overrun_out = overrun_q;
`else
    assign bus_io.cmd_overrun_out = 1'b0;
`endif
endmodule

// File: tb/tb_enet_bus_controller.sv
// Bench for enet_bus_controller: per-cycle trace model plus directed literal checks.
module tb_enet_bus_controller;
    localparam int P    = 2;
    localparam int G    = 2;
    localparam int STD  = 4;
    localparam int LONG = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    enet_bus_controller_if bus ();

    enet_bus_controller #(
        .PULSE_CYCLES      (P),
        .GAP_CYCLES        (G),
        .STD_DELAY_CYCLES  (STD),
        .LONG_DELAY_CYCLES (LONG)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct packed {
        logic        rdy;
        logic        cs_n;
        logic        cmd;
        logic        ior_n;
        logic        iow_n;
        logic        oe;
        logic [15:0] data;
        logic [15:0] datar;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t cur_e;
    logic cur_rdy = 1'b1;
    logic [15:0] model_datar = 16'd0;
    logic model_ovr = 1'b0;

    logic [15:0] snap_data[16];
    logic        snap_iow[16];
    logic        snap_ior[16];
    logic        snap_cmd[16];
    logic        snap_oe[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_n(input int n, input exp_t v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    // Trace model: on an accepted command, lay down every busy cycle's expected outputs.
    always @(posedge clk or posedge rst) begin : model
        exp_t v;
        logic is_idx, is_rd;
        int   dly;
        if (rst) begin
            exp_q.delete();
            model_datar = 16'd0;
            model_ovr   = 1'b0;
            cur_rdy     = 1'b1;
        end else if (bus.start_comm_in) begin
            if (cur_rdy) begin
                is_idx = (bus.comm_type_in == 2'd0) || (bus.comm_type_in == 2'd1);
                is_rd  = (bus.comm_type_in == 2'd0) || (bus.comm_type_in == 2'd3);
                dly    = (bus.post_command_delay_in == 3'd1) ? STD :
                         (bus.post_command_delay_in == 3'd2) ? LONG : 0;
                v = '{rdy: 1'b0, cs_n: 1'b0, cmd: 1'b0, ior_n: 1'b1, iow_n: 1'b0, oe: 1'b1,
                      data: {8'h00, bus.addr_in}, datar: model_datar};
                if (is_idx) begin
                    push_n(P, v);
                    v.iow_n = 1'b1;
                    v.oe    = 1'b0;
                    push_n(G, v);
                end
                v.cmd   = 1'b1;
                v.ior_n = !is_rd;
                v.iow_n = is_rd;
                v.oe    = !is_rd;
                v.data  = bus.dataw_in;
                push_n(P, v);
                if (is_rd) model_datar = bus.enet_data_in;
                v = '{rdy: 1'b0, cs_n: 1'b1, cmd: 1'b0, ior_n: 1'b1, iow_n: 1'b1, oe: 1'b0,
                      data: 16'd0, datar: model_datar};
                push_n(dly, v);
            end else begin
`ifdef ENET_OVERRUN_DETECT_EN
                model_ovr = 1'b1;
`endif
            end
        end
    end

    always @(negedge clk) begin : compare
        logic ok;
        if (!rst) begin
            if (exp_q.size() > 0) begin
                cur_e = exp_q.pop_front();
            end else begin
                cur_e = '{rdy: 1'b1, cs_n: 1'b1, cmd: 1'b0, ior_n: 1'b1, iow_n: 1'b1, oe: 1'b0,
                          data: 16'd0, datar: model_datar};
            end
            cur_rdy = cur_e.rdy;
            ok = (bus.rdy_out === cur_e.rdy) && (bus.enet_cs_n_out === cur_e.cs_n) &&
                 (bus.enet_ior_n_out === cur_e.ior_n) && (bus.enet_iow_n_out === cur_e.iow_n) &&
                 (bus.enet_data_oe_out === cur_e.oe) && (bus.datar_out === cur_e.datar) &&
                 (cur_e.cs_n || bus.enet_cmd_out === cur_e.cmd) &&
                 (!cur_e.oe || bus.enet_data_out === cur_e.data) &&
                 (bus.cmd_overrun_out === model_ovr);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL bus_cycle @%0t: got rdy=%b cs_n=%b cmd=%b ior_n=%b iow_n=%b oe=%b data=%h datar=%h ovr=%b, expected rdy=%b cs_n=%b cmd=%b ior_n=%b iow_n=%b oe=%b data=%h datar=%h ovr=%b",
                         $time, bus.rdy_out, bus.enet_cs_n_out, bus.enet_cmd_out,
                         bus.enet_ior_n_out, bus.enet_iow_n_out, bus.enet_data_oe_out,
                         bus.enet_data_out, bus.datar_out, bus.cmd_overrun_out,
                         cur_e.rdy, cur_e.cs_n, cur_e.cmd, cur_e.ior_n, cur_e.iow_n, cur_e.oe,
                         cur_e.data, cur_e.datar, model_ovr);
            end
        end
    end

    // Issues one command; lat = cycles from the start cycle until rdy_out is seen high.
    task automatic run_cmd(input logic [1:0] t, input logic [7:0] a, input logic [15:0] w,
                           input logic [2:0] d, input int inject_at, output int lat);
        @(negedge clk);
        bus.comm_type_in          = t;
        bus.addr_in               = a;
        bus.dataw_in              = w;
        bus.post_command_delay_in = d;
        bus.start_comm_in         = 1'b1;
        lat = 0;
        while (lat < 1000) begin
            @(negedge clk);
            lat++;
            bus.start_comm_in = (lat == inject_at);
            if (lat < 16) begin
                snap_data[lat] = bus.enet_data_out;
                snap_iow[lat]  = bus.enet_iow_n_out;
                snap_ior[lat]  = bus.enet_ior_n_out;
                snap_cmd[lat]  = bus.enet_cmd_out;
                snap_oe[lat]   = bus.enet_data_oe_out;
            end
            if (bus.rdy_out) break;
        end
        bus.start_comm_in = 1'b0;
        if (lat >= 1000) begin
            errors++;
            $display("FAIL rdy_timeout: rdy_out still low after %0d cycles", lat);
        end
    endtask

    initial begin
        int   lat;
        logic exp_ovr;
        bus.start_comm_in         = 1'b0;
        bus.comm_type_in          = 2'd0;
        bus.addr_in               = 8'd0;
        bus.dataw_in              = 16'd0;
        bus.post_command_delay_in = 3'd0;
        bus.enet_data_in          = 16'd0;
        #1 rst = 1'b1;
        #2;
        chk("reset_rdy",   32'(bus.rdy_out), 32'd1);
        chk("reset_cs_n",  32'(bus.enet_cs_n_out), 32'd1);
        chk("reset_iow_n", 32'(bus.enet_iow_n_out), 32'd1);
        chk("reset_ior_n", 32'(bus.enet_ior_n_out), 32'd1);
        chk("reset_oe",    32'(bus.enet_data_oe_out), 32'd0);
        chk("reset_datar", 32'(bus.datar_out), 32'd0);
        chk("reset_ovr",   32'(bus.cmd_overrun_out), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        run_cmd(2'd1, 8'hFE, 16'h003F, 3'd0, 0, lat);
        chk("write_latency", 32'(lat), 32'd7);
        chk("write_idx_data", 32'(snap_data[1]), 32'h00FE);
        chk("write_idx_iow", 32'(snap_iow[1]), 32'd0);
        chk("write_idx_cmd", 32'(snap_cmd[2]), 32'd0);
        chk("write_gap_iow", 32'(snap_iow[3]), 32'd1);
        chk("write_dat_data", 32'(snap_data[5]), 32'h003F);
        chk("write_dat_cmd", 32'(snap_cmd[6]), 32'd1);

        bus.enet_data_in = 16'h0003;
        run_cmd(2'd0, 8'hFE, 16'h0000, 3'd0, 0, lat);
        chk("read_latency", 32'(lat), 32'd7);
        chk("read_ior", 32'(snap_ior[5]), 32'd0);
        chk("read_oe", 32'(snap_oe[5]), 32'd0);
        chk("read_datar", 32'(bus.datar_out), 32'h0003);

        bus.enet_data_in = 16'hA55A;
        run_cmd(2'd3, 8'h00, 16'h0000, 3'd0, 0, lat);
        chk("rx_latency", 32'(lat), 32'd3);
        chk("rx_cmd", 32'(snap_cmd[1]), 32'd1);
        chk("rx_datar", 32'(bus.datar_out), 32'hA55A);

        bus.enet_data_in = 16'h0000;
        run_cmd(2'd2, 8'h00, 16'h1234, 3'd0, 0, lat);
        chk("tx_latency", 32'(lat), 32'd3);
        chk("tx_data", 32'(snap_data[1]), 32'h1234);
        chk("tx_cmd", 32'(snap_cmd[1]), 32'd1);
        chk("tx_datar_kept", 32'(bus.datar_out), 32'hA55A);

        run_cmd(2'd1, 8'h10, 16'h5555, 3'd0, 3, lat);
        chk("overrun_cmd_latency", 32'(lat), 32'd7);
`ifdef ENET_OVERRUN_DETECT_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        chk("overrun_flag", 32'(bus.cmd_overrun_out), 32'(exp_ovr));

        run_cmd(2'd1, 8'h1F, 16'h0001, 3'd2, 0, lat);
        chk("delay_long_latency", 32'(lat), 32'd207);
        run_cmd(2'd1, 8'h1F, 16'h0001, 3'd1, 0, lat);
        chk("delay_std_latency", 32'(lat), 32'd11);
        run_cmd(2'd1, 8'h1F, 16'h0001, 3'd5, 0, lat);
        chk("delay_other_latency", 32'(lat), 32'd7);
        chk("overrun_sticky", 32'(bus.cmd_overrun_out), 32'(exp_ovr));

        // Abort a WRITE in its data strobe with an asynchronous reset.
        @(negedge clk);
        bus.comm_type_in  = 2'd1;
        bus.addr_in       = 8'h22;
        bus.dataw_in      = 16'hCAFE;
        bus.start_comm_in = 1'b1;
        @(negedge clk);
        bus.start_comm_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_in_strobe", 32'(bus.enet_iow_n_out), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("abort_iow_n", 32'(bus.enet_iow_n_out), 32'd1);
        chk("abort_cs_n", 32'(bus.enet_cs_n_out), 32'd1);
        chk("abort_oe", 32'(bus.enet_data_oe_out), 32'd0);
        chk("abort_rdy", 32'(bus.rdy_out), 32'd1);
        chk("abort_datar", 32'(bus.datar_out), 32'd0);
        chk("abort_ovr", 32'(bus.cmd_overrun_out), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        bus.enet_data_in = 16'hBEEF;
        run_cmd(2'd0, 8'h05, 16'h0000, 3'd0, 0, lat);
        chk("post_reset_latency", 32'(lat), 32'd7);
        chk("post_reset_datar", 32'(bus.datar_out), 32'hBEEF);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/enet_bus_controller.md
Name: enet_bus_controller

Overview:
- Executes single register/data-port commands on the Ethernet MAC chip's 16-bit host bus (index/data, CMD-selected, DM9000A-style).
- Sits directly downstream of the interrupt detector, TX and RX engines, after their request/grant mux. It consumes start_comm/comm_type/addr/dataw/post_command_delay and returns rdy and datar.
- Generates CS_n/IOR_n/IOW_n/CMD strobes with programmable pulse width, inter-phase gap and post-command delay.

Parameters:
- PULSE_CYCLES, 2, IOR_n/IOW_n low width in clocks (1..15).
- GAP_CYCLES, 2, strobe-high cycles between index phase and data phase (1..15).
- STD_DELAY_CYCLES, 4, post-command idle for delay code 1.
- LONG_DELAY_CYCLES, 200, post-command idle for delay code 2 (PHY/EEPROM writes). Maximum 255.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- start_comm_in  in  1  one-cycle command start; accepted only when rdy_out=1.
- comm_type_in  in  2  0=READ (index+data read), 1=WRITE (index+data write), 2=TX (data-only write), 3=RX (data-only read).
- addr_in  in  8  register index, used by READ/WRITE only.
- dataw_in  in  16  write data.
- post_command_delay_in  in  3  0=none, 1=STD, 2=LONG, other values=none.
- rdy_out  out  1  controller idle and able to accept a command.
- datar_out  out  16  data returned by the last READ/RX.
- enet_cs_n_out  out  1  chip select, active low.
- enet_cmd_out  out  1  0=index port, 1=data port.
- enet_ior_n_out  out  1  read strobe, active low.
- enet_iow_n_out  out  1  write strobe, active low.
- enet_data_out  out  16  bus drive value.
- enet_data_oe_out  out  1  bus output enable (tristate at top level).
- enet_data_in  in  16  bus read value.
- cmd_overrun_out  out  1  sticky overrun flag (see Optional Feature).

Behaviour:
- Reset (async) values: state IDLE, rdy_out=1, datar_out=0, cs_n=1, ior_n=1, iow_n=1, cmd=0, data_out=0, data_oe=0, cmd_overrun_out=0. Reset mid-command aborts immediately and releases all strobes.
- Command acceptance:
  - rdy_out=1 only in IDLE.
  - When start_comm_in=1 in IDLE, addr, dataw, type and delay are latched and rdy_out drops the next cycle.
  - start_comm_in while rdy_out=0 is ignored.
- States: IDLE, IDX_STROBE, IDX_GAP, DATA_STROBE, POST_DELAY.
- READ/WRITE: IDLE -> IDX_STROBE (cmd=0, data_out=addr zero-extended, oe=1, iow_n=0 for PULSE_CYCLES) -> IDX_GAP (iow_n=1, cs_n=0, GAP_CYCLES) -> DATA_STROBE.
- TX/RX: IDLE -> DATA_STROBE directly.
- DATA_STROBE (cmd=1, PULSE_CYCLES):
  - Write types: oe=1, data_out=dataw, iow_n=0.
  - Read types: oe=0, ior_n=0. datar_out captures enet_data_in on the last strobe cycle.
- After DATA_STROBE, go to POST_DELAY if delay count > 0, otherwise IDLE.
- POST_DELAY: strobes high, cs_n=1, oe=0 for the selected cycle count, then IDLE.
- cs_n=0 from the first strobe cycle through the end of DATA_STROBE. cmd holds its value throughout each phase.
- Latency from start to rdy_out re-asserting:
  - READ/WRITE: 1 + 2*PULSE + GAP + delay cycles (with defaults and no delay: 7).
  - TX/RX: 1 + PULSE + delay cycles (defaults: 3).
- Phase counter is 8 bits and counts down. No wrap is possible within the parameter limits.
- ior_n and iow_n are never low at the same time. oe=0 whenever ior_n=0.
- datar_out holds its value until the next READ/RX completes. WRITE/TX commands leave it unchanged.

Optional Feature:
- Macro: ENET_OVERRUN_DETECT_EN.
- Defined: cmd_overrun_out is set when start_comm_in=1 while rdy_out=0. It is sticky and cleared only by Reset.
- Not defined: cmd_overrun_out is tied to 0 and no detection logic is built.

Test Plan:
- WRITE addr=0xFE, dataw=0x003F, delay 0 -> iow_n low 2 cycles with cmd=0 and data=0x00FE; 2 gap cycles; iow_n low 2 cycles with cmd=1 and data=0x003F; rdy_out high 7 cycles after start.
- READ addr=0xFE, bus returns 0x0003 during the data strobe -> datar_out=0x0003, oe=0 during ior_n low, rdy_out back after 7 cycles.
- RX with bus value 0xA55A, then TX with dataw=0x1234 -> each takes a single data phase only (cmd=1, no index strobe); datar_out=0xA55A and unchanged after the TX.
- WRITE with delay=2 -> rdy_out stays low 7+200 cycles; delay=1 gives 7+4; delay=5 gives 7.
- start_comm pulse mid-command -> ignored, bus sequence unchanged. With ENET_OVERRUN_DETECT_EN, cmd_overrun_out=1 and stays 1 until Reset.
- Reset asserted during DATA_STROBE -> all strobes high, oe=0, rdy_out=1 immediately (async); the next command executes normally.
